// File: rtl/one_run_counter_8b_pkg.sv
// Shared definitions for the one-run counter: FSM state encoding and default widths.
package one_run_counter_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int DIV_WIDTH_DEF = 30;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

endpackage

// File: rtl/one_run_counter_8b_if.sv
// Control/status bundle of the one-run counter: divider period, run limit, trigger and results.
interface one_run_counter_8b_if
  import one_run_counter_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) ();

  logic [DIV_WIDTH-1:0] period;
  logic [WIDTH-1:0]     limit;
  logic                 run;
  logic                 clk_out;
  logic [WIDTH-1:0]     out;
  logic                 carry;

  modport master (
    output period,
    output limit,
    output run,
    input  clk_out,
    input  out,
    input  carry
  );

  modport slave (
    input  period,
    input  limit,
    input  run,
    output clk_out,
    output out,
    output carry
  );

endinterface

// File: rtl/one_run_counter_8b_freq_divider.sv
// Programmable divider: clk_out toggles every max(period,1) qzt_clk cycles (50% duty).
module freq_divider
  import one_run_counter_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 qzt_clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 clk_out
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] period_eff;
  logic                 clk_out_q, clk_out_d;

  // period is re-read every compare, so a new value applies at the next wrap without a glitch
  always_comb begin
    period_eff = (period == '0) ? ONE : period;
    div_cnt_d  = div_cnt_q + ONE;
    clk_out_d  = clk_out_q;
    if (div_cnt_q >= period_eff - ONE) begin
      div_cnt_d = '0;
      clk_out_d = ~clk_out_q;
    end
  end

  always_ff @(posedge qzt_clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      clk_out_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: rtl/one_run_counter_8b.sv
// Single-shot up-counter clocked by divided-clock ticks, restarted by a synchronized run edge.
// Build option CARRY_STICKY_EN: carry holds from completion until the next arm or reset.
module one_run_counter_8b
  import one_run_counter_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                qzt_clk,
  input  logic                rst,
  one_run_counter_8b_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             clk_div;
  logic             clk_div_dly_q;
  logic             run_s1_q, run_s2_q, run_s3_q;
  logic             arm, tick;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;

  freq_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .qzt_clk (qzt_clk),
    .rst     (rst),
    .period  (bus.period),
    .clk_out (clk_div)
  );

  // run_s3_q only serves edge detection on the synchronized trigger
  assign arm  = run_s2_q & ~run_s3_q;
  assign tick = clk_div & ~clk_div_dly_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef CARRY_STICKY_EN
    carry_d = carry_q;
`else
    carry_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arm) begin
          out_d   = '0;
          carry_d = 1'b0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (arm) begin
          out_d   = '0;
          carry_d = 1'b0;
        end else if (out_q == bus.limit) begin
          carry_d = 1'b1;
          state_d = IDLE;
        end else if (tick) begin
          out_d = out_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge qzt_clk or posedge rst) begin
    if (rst) begin
      run_s1_q      <= 1'b0;
      run_s2_q      <= 1'b0;
      run_s3_q      <= 1'b0;
      clk_div_dly_q <= 1'b0;
      state_q       <= IDLE;
      out_q         <= '0;
      carry_q       <= 1'b0;
    end else begin
      run_s1_q      <= bus.run;
      run_s2_q      <= run_s1_q;
      run_s3_q      <= run_s2_q;
      clk_div_dly_q <= clk_div;
      state_q       <= state_d;
      out_q         <= out_d;
      carry_q       <= carry_d;
    end
  end

  assign bus.clk_out = clk_div;
  assign bus.out     = out_q;
  assign bus.carry   = carry_q;

endmodule

// File: tb/tb_one_run_counter_8b.sv
// Directed bench for one_run_counter_8b: reset, divider, runs, limit=0, held run, retrigger, carry mode.
module tb_one_run_counter_8b;

  logic qzt_clk = 1'b0;
  logic rst     = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  one_run_counter_8b_if #(.WIDTH(8), .DIV_WIDTH(30)) bus ();

  one_run_counter_8b #(.WIDTH(8), .DIV_WIDTH(30)) dut (
    .qzt_clk (qzt_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #20 qzt_clk = ~qzt_clk;

`ifdef CARRY_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge qzt_clk);
      #1;
    end
  endtask

  // Drives run (initial pulse and optional retrigger) and collects observations; no judging here.
  task automatic watch(input int cycles, input int run_cycles, input int retrig_val,
                       output int rises, output int highs, output int bad_steps,
                       output int restarts, output int lim_idx, output int carry_idx,
                       output int spacing_bad);
    logic [7:0] last;
    logic       last_c;
    int         last_chg;
    int         run_left;
    bit         retrig_done;
    last = bus.out; last_c = bus.carry;
    rises = 0; highs = 0; bad_steps = 0; restarts = 0; spacing_bad = 0;
    lim_idx = -1; carry_idx = -1; last_chg = -1; retrig_done = 1'b0;
    run_left = run_cycles;
    bus.run = (run_cycles > 0);
    for (int i = 0; i < cycles; i++) begin
      tick_n(1);
      if (run_left > 0) begin
        run_left--;
        if (run_left == 0) bus.run = 1'b0;
      end
      if (bus.out !== last) begin
        if (bus.out == 8'd0) begin
          restarts++;
          last_chg = -1;
        end else begin
          if (bus.out !== last + 8'd1) bad_steps++;
          if (last_chg >= 0 && (i - last_chg) != 2) spacing_bad++;
          last_chg = i;
        end
        if (bus.out == bus.limit) lim_idx = i;
        last = bus.out;
      end
      if (bus.carry && !last_c) begin
        rises++;
        if (carry_idx < 0) carry_idx = i;
      end
      if (bus.carry) highs++;
      last_c = bus.carry;
      if (retrig_val >= 0 && !retrig_done && bus.out == retrig_val) begin
        bus.run = 1'b1;
        run_left = 3;
        retrig_done = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    #3 rst = 1'b1;
    #2;
    total++; if (bus.out !== 8'd0) begin bad++; $display("FAIL reset_out got=%0d want=0", bus.out); end
    total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", bus.carry); end
    total++; if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out got=%b want=0", bus.clk_out); end
    tick_n(2);
    rst = 1'b0;
    tick_n(1);
  endtask

  task automatic test_divider;
    logic prev;
    int   n;
    bus.period = 30'd1;
    tick_n(1);
    prev = bus.clk_out;
    for (int k = 0; k < 4; k++) begin
      tick_n(1);
      total++;
      if (bus.clk_out !== ~prev) begin
        bad++; $display("FAIL div_p1_toggle got=%b want=%b", bus.clk_out, ~prev);
      end
      prev = bus.clk_out;
    end
    bus.period = 30'd3;
    prev = bus.clk_out; n = 0;
    do begin tick_n(1); n++; end while (bus.clk_out === prev && n < 20);
    for (int k = 0; k < 2; k++) begin
      prev = bus.clk_out; n = 0;
      do begin tick_n(1); n++; end while (bus.clk_out === prev && n < 20);
      total++;
      if (n != 3) begin bad++; $display("FAIL div_p3_half got=%0d cycles want=3", n); end
    end
    bus.period = 30'd1;
    tick_n(4);
  endtask

  task automatic test_basic_run;
    int rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad;
    bus.limit = 8'd5;
    watch(40, 3, -1, rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad);
    total++; if (bsteps != 0) begin bad++; $display("FAIL basic_steps got=%0d bad steps want=0", bsteps); end
    total++; if (sp_bad != 0) begin bad++; $display("FAIL basic_spacing got=%0d bad gaps want=0", sp_bad); end
    total++; if (restarts != 0) begin bad++; $display("FAIL basic_restarts got=%0d want=0", restarts); end
    total++; if (rises != 1) begin bad++; $display("FAIL basic_carry_count got=%0d want=1", rises); end
    total++; if (lim_idx < 0 || carry_idx != lim_idx + 1) begin
      bad++; $display("FAIL basic_carry_time got=%0d want=%0d", carry_idx, lim_idx + 1);
    end
    total++; if (bus.out !== 8'd5) begin bad++; $display("FAIL basic_hold got=%0d want=5", bus.out); end
    if (STICKY) begin
      total++; if (bus.carry !== 1'b1) begin bad++; $display("FAIL basic_carry_sticky got=%b want=1", bus.carry); end
    end else begin
      total++; if (highs != 1) begin bad++; $display("FAIL basic_carry_width got=%0d want=1", highs); end
    end
  endtask

  task automatic test_limit_zero;
    int rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad;
    bus.limit = 8'd0;
    watch(20, 3, -1, rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad);
    total++; if (bus.out !== 8'd0) begin bad++; $display("FAIL lim0_out got=%0d want=0", bus.out); end
    total++; if (rises != 1) begin bad++; $display("FAIL lim0_carry_count got=%0d want=1", rises); end
    total++; if (carry_idx != 3) begin bad++; $display("FAIL lim0_carry_time got=%0d want=3", carry_idx); end
    total++; if (bsteps != 0) begin bad++; $display("FAIL lim0_steps got=%0d want=0", bsteps); end
  endtask

  task automatic test_run_held;
    int rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad;
    bus.limit = 8'd5;
    watch(60, 50, -1, rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad);
    total++; if (rises != 1) begin bad++; $display("FAIL held_carry_count got=%0d want=1", rises); end
    total++; if (restarts != 0) begin bad++; $display("FAIL held_restarts got=%0d want=0", restarts); end
    total++; if (bus.out !== 8'd5) begin bad++; $display("FAIL held_out got=%0d want=5", bus.out); end
  endtask

  task automatic test_retrigger;
    int rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad;
    bus.limit = 8'd5;
    watch(60, 3, 3, rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad);
    total++; if (restarts != 2) begin bad++; $display("FAIL retrig_restarts got=%0d want=2", restarts); end
    total++; if (rises != 1) begin bad++; $display("FAIL retrig_carry_count got=%0d want=1", rises); end
    total++; if (bsteps != 0) begin bad++; $display("FAIL retrig_steps got=%0d want=0", bsteps); end
    total++; if (lim_idx < 0 || carry_idx != lim_idx + 1) begin
      bad++; $display("FAIL retrig_carry_time got=%0d want=%0d", carry_idx, lim_idx + 1);
    end
    total++; if (bus.out !== 8'd5) begin bad++; $display("FAIL retrig_out got=%0d want=5", bus.out); end
  endtask

  task automatic test_reset_mid_run;
    int rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad;
    bus.limit = 8'd5;
    bus.run = 1'b1;
    tick_n(3);
    bus.run = 1'b0;
    tick_n(6);
    total++; if (bus.out == 8'd0) begin bad++; $display("FAIL midrst_pre_out got=%0d want=nonzero", bus.out); end
    #10 rst = 1'b1;
    #1;
    total++; if (bus.out !== 8'd0) begin bad++; $display("FAIL midrst_out got=%0d want=0", bus.out); end
    total++; if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL midrst_clk_out got=%b want=0", bus.clk_out); end
    tick_n(2);
    rst = 1'b0;
    watch(20, 0, -1, rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad);
    total++; if (highs != 0) begin bad++; $display("FAIL midrst_carry got=%0d high cycles want=0", highs); end
    total++; if (bus.out !== 8'd0) begin bad++; $display("FAIL midrst_idle_out got=%0d want=0", bus.out); end
  endtask

  task automatic test_carry_mode;
    int rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad;
    bus.limit = 8'd2;
    watch(30, 3, -1, rises, highs, bsteps, restarts, lim_idx, carry_idx, sp_bad);
    total++; if (rises != 1) begin bad++; $display("FAIL mode_carry_count got=%0d want=1", rises); end
    total++; if (bus.carry !== STICKY) begin bad++; $display("FAIL mode_carry_after got=%b want=%b", bus.carry, STICKY); end
    bus.run = 1'b1;
    tick_n(2);
    total++; if (bus.carry !== STICKY) begin bad++; $display("FAIL mode_carry_pre_arm got=%b want=%b", bus.carry, STICKY); end
    tick_n(1);
    total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL mode_carry_clear got=%b want=0", bus.carry); end
    total++; if (bus.out !== 8'd0) begin bad++; $display("FAIL mode_restart_out got=%0d want=0", bus.out); end
    bus.run = 1'b0;
    tick_n(20);
  endtask

  initial begin
    bus.period = 30'd1;
    bus.limit  = 8'd5;
    bus.run    = 1'b0;
    test_reset();
    test_divider();
    test_basic_run();
    test_limit_zero();
    test_run_held();
    test_retrigger();
    test_reset_mid_run();
    test_carry_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
